// File: rtl/buffer_dma_engine_pkg.sv
// Shared accelerator package: DMA engine states, status codes and
// default sizing constants.
package buffer_dma_engine_pkg;

   localparam int unsigned DMA_N_PE     = 16;
   localparam int unsigned DMA_N_BUF    = 2;
   localparam int unsigned DMA_DATA_W   = 16;
   localparam int unsigned DMA_ADDR_EXT = 32;
   localparam int unsigned DMA_ADDR_RAM = 10;
   localparam int unsigned DMA_RD_LAT   = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FINISH
   } dma_state_e;

   typedef enum logic [1:0] {
      STAT_OK    = 2'b00,
      STAT_ABORT = 2'b01,
      STAT_BAD   = 2'b10
   } dma_status_e;

endpackage

// File: rtl/buffer_dma_engine_dma_ptr_bank.sv
// Per-bank write/read pointer array, one pointer per (buffer, bank)
// pair, with global clear and single-entry post-increment.
module dma_ptr_bank #(
   parameter int unsigned N_PTR = 32,
   parameter int unsigned AW    = 10,
   parameter int unsigned IW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   input  logic [IW-1:0] idx,
   output logic [AW-1:0] ptr
);

   logic [AW-1:0] ptr_q [N_PTR];
   logic [AW-1:0] ptr_d [N_PTR];

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         for (int i = 0; i < int'(N_PTR); i++) ptr_d[i] = '0;
      end else if (inc) begin
         // Wraps modulo 2^AW by natural overflow.
         ptr_d[idx] = ptr_q[idx] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_PTR); i++) ptr_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q[idx];

endmodule

// File: rtl/buffer_dma_engine.sv
// Strided DMA between external memory and banked on-chip buffers,
// one word per cycle, with abort and layer-boundary pointer clear.
module buffer_dma_engine
   import buffer_dma_engine_pkg::*;
#(
   parameter int unsigned N_PE     = DMA_N_PE,
   parameter int unsigned N_BUF    = DMA_N_BUF,
   parameter int unsigned DATA_W   = DMA_DATA_W,
   parameter int unsigned ADDR_EXT = DMA_ADDR_EXT,
   parameter int unsigned ADDR_RAM = DMA_ADDR_RAM,
   parameter int unsigned RD_LAT   = DMA_RD_LAT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_dir,
   input  logic [ADDR_EXT-1:0]       cmd_ext_start,
   input  logic [15:0]               cmd_ext_stride,
   input  logic [31:0]               cmd_words,
   input  logic [$clog2(N_BUF)-1:0]  cmd_buf,
   input  logic [$clog2(N_PE):0]     cmd_bank,
   input  logic                      ptr_clr,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                status,
   output logic                      ext_re,
   output logic [ADDR_EXT-1:0]       ext_rd_addr,
   input  logic [DATA_W-1:0]         ext_rd_data,
   output logic                      ext_we,
   output logic [ADDR_EXT-1:0]       ext_wr_addr,
   output logic [DATA_W-1:0]         ext_wr_data,
   output logic [$clog2(N_BUF)-1:0]  buf_sel,
   output logic [N_PE-1:0]           buf_w_en,
   output logic [ADDR_RAM-1:0]       buf_w_addr,
   output logic [DATA_W-1:0]         buf_w_data,
   output logic [N_PE-1:0]           buf_r_en,
   output logic [ADDR_RAM-1:0]       buf_r_addr,
   input  logic [DATA_W-1:0]         buf_r_data
);

   localparam int unsigned BUF_W  = $clog2(N_BUF);
   localparam int unsigned BANK_W = $clog2(N_PE);
   localparam int unsigned IDX_W  = $clog2(N_BUF * N_PE);

   dma_state_e          state_q, state_d;
   logic [1:0]          status_q, status_d;
   logic                dir_q, dir_d;
   logic [ADDR_EXT-1:0] addr_q, addr_d;
   logic [15:0]         stride_q, stride_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [BUF_W-1:0]    buf_q, buf_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic                wvld_q, wvld_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rvld_q, rvld_d;
   logic [ADDR_EXT-1:0] waddr_q, waddr_d;
   logic                pend_clr_q, pend_clr_d;

   logic                issue;
   logic                ld_issue;
   logic                sv_issue;
   logic                cmd_bad;
   logic                clr;
   logic [IDX_W-1:0]    ptr_idx;
   logic [ADDR_RAM-1:0] ptr;
   logic [N_PE-1:0]     bank_oh;

   assign issue    = (state_q == ST_ISSUE);
   assign ld_issue = issue && !dir_q;
   assign sv_issue = issue && dir_q;
   assign cmd_bad  = (int'(cmd_bank) >= int'(N_PE)) ||
                     (int'(cmd_buf) >= int'(N_BUF));

   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      dir_d      = dir_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      bank_d     = bank_q;
      pend_clr_d = pend_clr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               dir_d    = cmd_dir;
               addr_d   = cmd_ext_start;
               stride_d = cmd_ext_stride;
               cnt_d    = cmd_words;
               buf_d    = cmd_buf;
               bank_d   = cmd_bank[BANK_W-1:0];
               status_d = STAT_OK;
               if (cmd_bad) begin
                  status_d = STAT_BAD;
                  state_d  = ST_FINISH;
               end else if (cmd_words == '0) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            addr_d = addr_q + ADDR_EXT'(stride_q);
            cnt_d  = cnt_q - 1'b1;
            if (abort) begin
               status_d = STAT_ABORT;
               state_d  = ST_DRAIN;
            end else if (cnt_q == 32'd1) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) status_d = STAT_ABORT;
            // The last buffer write or ext write retires this cycle.
            if (vld_q == '0) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d    = ST_IDLE;
            pend_clr_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      if (ptr_clr && (state_q == ST_ISSUE || state_q == ST_DRAIN))
         pend_clr_d = 1'b1;
   end

   always_comb begin
      vld_d   = (vld_q << 1) | RD_LAT'(ld_issue);
      wvld_d  = vld_q[RD_LAT-1];
      wdata_d = vld_q[RD_LAT-1] ? ext_rd_data : wdata_q;
      rvld_d  = sv_issue;
      waddr_d = sv_issue ? addr_q : waddr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         status_q   <= STAT_OK;
         dir_q      <= 1'b0;
         addr_q     <= '0;
         stride_q   <= '0;
         cnt_q      <= '0;
         buf_q      <= '0;
         bank_q     <= '0;
         vld_q      <= '0;
         wvld_q     <= 1'b0;
         wdata_q    <= '0;
         rvld_q     <= 1'b0;
         waddr_q    <= '0;
         pend_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         dir_q      <= dir_d;
         addr_q     <= addr_d;
         stride_q   <= stride_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         bank_q     <= bank_d;
         vld_q      <= vld_d;
         wvld_q     <= wvld_d;
         wdata_q    <= wdata_d;
         rvld_q     <= rvld_d;
         waddr_q    <= waddr_d;
         pend_clr_q <= pend_clr_d;
      end
   end

   assign clr = (state_q == ST_IDLE && ptr_clr) ||
                (state_q == ST_FINISH && (pend_clr_q || ptr_clr));

   assign ptr_idx = IDX_W'(int'(buf_q) * int'(N_PE) + int'(bank_q));

   dma_ptr_bank #(
      .N_PTR (N_BUF * N_PE),
      .AW    (ADDR_RAM),
      .IW    (IDX_W)
   ) u_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (wvld_q || sv_issue),
      .idx   (ptr_idx),
      .ptr   (ptr)
   );

   assign bank_oh     = N_PE'(1) << bank_q;
   assign cmd_ready   = (state_q == ST_IDLE) && rst_n;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FINISH);
   assign status      = status_q;
   assign ext_re      = ld_issue;
   assign ext_rd_addr = addr_q;
   assign ext_we      = rvld_q;
   assign ext_wr_addr = waddr_q;
   assign ext_wr_data = buf_r_data;
   assign buf_sel     = buf_q;
   assign buf_w_en    = wvld_q ? bank_oh : '0;
   assign buf_w_addr  = ptr;
   assign buf_w_data  = wdata_q;
   assign buf_r_en    = sv_issue ? bank_oh : '0;
   assign buf_r_addr  = ptr;

endmodule

// File: tb/tb_buffer_dma_engine.sv
// Directed bench for buffer_dma_engine with external-memory and
// banked-buffer models.
module tb_buffer_dma_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [31:0] cmd_ext_start = '0;
   logic [15:0] cmd_ext_stride = '0;
   logic [31:0] cmd_words = '0;
   logic [0:0]  cmd_buf = '0;
   logic [4:0]  cmd_bank = '0;
   logic        ptr_clr = 1'b0;
   logic        abort = 1'b0;
   logic        busy, done;
   logic [1:0]  status;
   logic        ext_re, ext_we;
   logic [31:0] ext_rd_addr, ext_wr_addr;
   logic [15:0] ext_rd_data, ext_wr_data;
   logic [0:0]  buf_sel;
   logic [15:0] buf_w_en, buf_r_en;
   logic [9:0]  buf_w_addr, buf_r_addr;
   logic [15:0] buf_w_data;
   logic [15:0] buf_r_data = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;

   buffer_dma_engine dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_dir        (cmd_dir),
      .cmd_ext_start  (cmd_ext_start),
      .cmd_ext_stride (cmd_ext_stride),
      .cmd_words      (cmd_words),
      .cmd_buf        (cmd_buf),
      .cmd_bank       (cmd_bank),
      .ptr_clr        (ptr_clr),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .status         (status),
      .ext_re         (ext_re),
      .ext_rd_addr    (ext_rd_addr),
      .ext_rd_data    (ext_rd_data),
      .ext_we         (ext_we),
      .ext_wr_addr    (ext_wr_addr),
      .ext_wr_data    (ext_wr_data),
      .buf_sel        (buf_sel),
      .buf_w_en       (buf_w_en),
      .buf_w_addr     (buf_w_addr),
      .buf_w_data     (buf_w_data),
      .buf_r_en       (buf_r_en),
      .buf_r_addr     (buf_r_addr),
      .buf_r_data     (buf_r_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_word(input logic [31:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   // External memory: data RD_LAT=2 cycles after the read strobe.
   logic [15:0] rd_pipe0 = '0, rd_pipe1 = '0;
   always @(posedge clk) begin
      rd_pipe0 <= ext_re ? mem_word(ext_rd_addr) : 16'hDEAD;
      rd_pipe1 <= rd_pipe0;
   end
   assign ext_rd_data = rd_pipe1;

   // Banked buffer with one-cycle read latency.
   logic [15:0] bmem [2][16][1024];
   always @(posedge clk) begin
      for (int b = 0; b < 16; b++) begin
         if (buf_w_en[b]) bmem[buf_sel][b][buf_w_addr] <= buf_w_data;
         if (buf_r_en[b]) buf_r_data <= bmem[buf_sel][b][buf_r_addr];
      end
   end

   int n_re, n_bw, n_we, n_br, n_done;
   bit overlap;
   logic [31:0] re_addr[$];
   logic [15:0] bw_en[$];
   logic [9:0]  bw_addr[$];
   logic [31:0] we_addr[$];
   logic [15:0] we_data[$];

   always @(negedge clk) begin
      if (ext_re) begin
         n_re++;
         re_addr.push_back(ext_rd_addr);
      end
      if (|buf_w_en) begin
         n_bw++;
         bw_en.push_back(buf_w_en);
         bw_addr.push_back(buf_w_addr);
      end
      if (ext_we) begin
         n_we++;
         we_addr.push_back(ext_wr_addr);
         we_data.push_back(ext_wr_data);
      end
      if (|buf_r_en) n_br++;
      if (done) n_done++;
      if ((|buf_w_en) && (|buf_r_en)) overlap = 1'b1;
   end

   task automatic clr_log();
      n_re = 0; n_bw = 0; n_we = 0; n_br = 0; n_done = 0;
      re_addr.delete(); bw_en.delete(); bw_addr.delete();
      we_addr.delete(); we_data.delete();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic dir, input logic [31:0] st,
                            input logic [15:0] sd, input logic [31:0] w,
                            input logic [0:0] b, input logic [4:0] bk);
      cmd_dir = dir; cmd_ext_start = st; cmd_ext_stride = sd;
      cmd_words = w; cmd_buf = b; cmd_bank = bk;
      cmd_valid = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic [1:0] st);
      lat = -1;
      st = 2'bxx;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - t0;
            st = status;
            break;
         end
      end
      if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_clr();
      ptr_clr = 1'b1;
      @(posedge clk); #1;
      ptr_clr = 1'b0;
   endtask

   int lat;
   logic [1:0] st;
   int nbw_rst;

   initial begin
      // Reset state
      #12;
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_re", ext_re, 0);
      chk("rst_we", ext_we, 0);
      chk("rst_wen", buf_w_en, 0);
      chk("rst_ren", buf_r_en, 0);
      chk("rst_status", status, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", cmd_ready, 1);

      // LOAD 4 words into buf0 bank3
      clr_log();
      start_cmd(1'b0, 32'h100, 16'd1, 32'd4, 1'b0, 5'd3);
      wait_done(lat, st);
      chk("load_lat", lat, 8);
      chk("load_status", st, 0);
      chk("load_nre", n_re, 4);
      chk("load_nbw", n_bw, 4);
      for (int i = 0; i < 4; i++) begin
         chk("load_re_addr", re_addr[i], 32'h100 + i);
         chk("load_wen", bw_en[i], 16'h0008);
         chk("load_waddr", bw_addr[i], i);
      end

      // LOAD buf1 bank0, clear pointers, SAVE back out strided
      start_cmd(1'b0, 32'h300, 16'd1, 32'd3, 1'b1, 5'd0);
      wait_done(lat, st);
      pulse_clr();
      clr_log();
      start_cmd(1'b1, 32'h200, 16'd4, 32'd3, 1'b1, 5'd0);
      wait_done(lat, st);
      chk("save_status", st, 0);
      chk("save_nwe", n_we, 3);
      chk("save_nbr", n_br, 3);
      chk("save_nbw", n_bw, 0);
      for (int i = 0; i < 3; i++) begin
         chk("save_addr", we_addr[i], 32'h200 + 4 * i);
         chk("save_data", we_data[i], mem_word(32'h300 + i));
      end

      // Pointer wrap at 1022
      pulse_clr();
      start_cmd(1'b0, 32'h0, 16'd0, 32'd1022, 1'b0, 5'd5);
      wait_done(lat, st);
      clr_log();
      start_cmd(1'b0, 32'h40, 16'd1, 32'd4, 1'b0, 5'd5);
      wait_done(lat, st);
      chk("wrap_nbw", n_bw, 4);
      chk("wrap_a0", bw_addr[0], 1022);
      chk("wrap_a1", bw_addr[1], 1023);
      chk("wrap_a2", bw_addr[2], 0);
      chk("wrap_a3", bw_addr[3], 1);
      clr_log();
      start_cmd(1'b0, 32'h50, 16'd1, 32'd1, 1'b0, 5'd5);
      wait_done(lat, st);
      chk("wrap_ptr_end", bw_addr[0], 2);

      // Abort at issue 10 of a 100-word load
      clr_log();
      start_cmd(1'b0, 32'h1000, 16'd2, 32'd100, 1'b0, 5'd7);
      repeat (10) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(lat, st);
      chk("abort_status", st, 2'b01);
      chk("abort_nre", n_re, 11);
      chk("abort_nbw", n_bw, 11);
      chk("abort_last_addr", re_addr[10], 32'h1014);

      // Bad bank and zero-length commands
      clr_log();
      start_cmd(1'b0, 32'h0, 16'd1, 32'd5, 1'b0, 5'd16);
      wait_done(lat, st);
      chk("bad_lat", lat, 1);
      chk("bad_status", st, 2'b10);
      chk("bad_strobes", n_re + n_bw + n_we + n_br, 0);
      clr_log();
      start_cmd(1'b1, 32'h0, 16'd1, 32'd0, 1'b0, 5'd2);
      wait_done(lat, st);
      chk("zero_lat", lat, 1);
      chk("zero_status", st, 0);
      chk("zero_strobes", n_re + n_bw + n_we + n_br, 0);

      // Abort in IDLE is ignored
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      start_cmd(1'b0, 32'h60, 16'd1, 32'd1, 1'b0, 5'd9);
      wait_done(lat, st);
      chk("idle_abort_status", st, 0);

      // ptr_clr while busy is deferred to FINISH
      pulse_clr();
      clr_log();
      start_cmd(1'b0, 32'h80, 16'd1, 32'd4, 1'b0, 5'd2);
      pulse_clr();
      wait_done(lat, st);
      chk("pclr_nbw", n_bw, 4);
      for (int i = 0; i < 4; i++) chk("pclr_addr", bw_addr[i], i);
      clr_log();
      start_cmd(1'b0, 32'h90, 16'd1, 32'd1, 1'b0, 5'd2);
      wait_done(lat, st);
      chk("pclr_after", bw_addr[0], 0);

      chk("rw_overlap", overlap, 0);

      // Reset mid-transfer
      clr_log();
      start_cmd(1'b0, 32'h400, 16'd1, 32'd20, 1'b0, 5'd1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_re", ext_re, 0);
      chk("mrst_wen", buf_w_en, 0);
      chk("mrst_done", done, 0);
      chk("mrst_status", status, 0);
      chk("mrst_ready", cmd_ready, 0);
      nbw_rst = n_bw;
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("mrst_no_done", n_done, 0);
      chk("mrst_no_late_wr", n_bw, nbw_rst);
      chk("mrst_ready_after", cmd_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
